dsp_nco_sweep_ctrl: RTL and testbench

DSP_NCO_SWEEP_CTRL -- requirements
Module: dsp_nco_sweep_ctrl

---
 rtl/dsp_nco_sweep_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dsp_nco_sweep_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_nco_sweep_ctrl.sv
// dsp_nco_sweep_ctrl: linear frequency sweep sequencer for an NCO phase-increment input.
// Steps from f_start to f_stop by f_step, holding each frequency for max(dwell,1) cycles.
// The sweep runs single-shot or continuous.
// Optional build macro DSP_NCO_SWEEP_BIDIR_EN: on reaching the top of the sweep, turn
// around and step back down to f_start (dir=1). Left undefined, sweeps are up-only and
// dir stays at 0.
//
// state | meaning
// IDLE  | outputs off, nco_phi_inc holds its last value, waiting for start
// DWELL | holding the current frequency, down-counter running
// STEP  | last hold cycle of the current frequency; the next frequency is chosen here
// DONE  | one-cycle completion pulse, then back to IDLE
module dsp_nco_sweep_ctrl #(
    parameter int PHI_WIDTH   = 14,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   cont,
    input  logic [PHI_WIDTH-1:0]   f_start,
    input  logic [PHI_WIDTH-1:0]   f_stop,
    input  logic [PHI_WIDTH-1:0]   f_step,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic                   nco_en,
    output logic [PHI_WIDTH-1:0]   nco_phi_inc,
    output logic                   busy,
    output logic                   step_stb,
    output logic                   done,
    output logic                   dir
);

    typedef enum logic [1:0] {IDLE, DWELL, STEP, DONE} state_t;

    state_t                 state, state_nx;
    logic [PHI_WIDTH-1:0]   phi, phi_nx;
    logic [PHI_WIDTH-1:0]   fs_lat, fstop_lat, fstep_lat;
    logic [DWELL_WIDTH-1:0] dwell_lat, cnt, cnt_nx;
    logic [DWELL_WIDTH-1:0] hold_in, hold_lat;
    logic                   cont_lat;
    logic                   stb_q, stb_nx;
    logic                   dir_q, dir_nx;
    logic                   cfg_load;
    logic [PHI_WIDTH:0]     up_sum;
    logic                   up_ok;
    logic                   sweep_end;
    logic                   load_freq;
`ifdef DSP_NCO_SWEEP_BIDIR_EN
    logic [PHI_WIDTH:0]     dn_diff;
    logic                   dn_ok;
`endif

    // The first hold cycle is the cycle a frequency is loaded and STEP is the last one,
    // so DWELL itself lasts max(dwell,1)-1 cycles.
    assign hold_in  = (dwell == '0)     ? '0 : dwell - DWELL_WIDTH'(1);
    assign hold_lat = (dwell_lat == '0) ? '0 : dwell_lat - DWELL_WIDTH'(1);
    assign cfg_load = (state == IDLE) && start && !abort;

    // Next-frequency candidates, one bit wider so that carry and borrow stay visible
    assign up_sum = {1'b0, phi} + {1'b0, fstep_lat};
    assign up_ok  = (fstep_lat != '0) && !up_sum[PHI_WIDTH] && (up_sum[PHI_WIDTH-1:0] <= fstop_lat);
`ifdef DSP_NCO_SWEEP_BIDIR_EN
    assign dn_diff = {1'b0, phi} - {1'b0, fstep_lat};
    assign dn_ok   = (fstep_lat != '0) && !dn_diff[PHI_WIDTH] && (dn_diff[PHI_WIDTH-1:0] >= fs_lat);
`endif

    // Sweep configuration is captured only when a start is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fs_lat    <= '0;
            fstop_lat <= '0;
            fstep_lat <= '0;
            dwell_lat <= '0;
            cont_lat  <= 1'b0;
        end else if (cfg_load) begin
            fs_lat    <= f_start;
            fstop_lat <= f_stop;
            fstep_lat <= f_step;
            dwell_lat <= dwell;
            cont_lat  <= cont;
        end
    end

    // State, frequency, dwell counter and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            phi   <= '0;
            cnt   <= '0;
            stb_q <= 1'b0;
            dir_q <= 1'b0;
        end else begin
            state <= state_nx;
            phi   <= phi_nx;
            cnt   <= cnt_nx;
            stb_q <= stb_nx;
            dir_q <= dir_nx;
        end
    end

    // Next-state and next-frequency selection; abort overrides everything
    always_comb begin
        state_nx  = state;
        phi_nx    = phi;
        cnt_nx    = cnt;
        stb_nx    = 1'b0;
        dir_nx    = dir_q;
        sweep_end = 1'b0;
        load_freq = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    phi_nx   = f_start;
                    stb_nx   = 1'b1;
                    dir_nx   = 1'b0;
                    cnt_nx   = hold_in;
                    state_nx = (hold_in == '0) ? STEP : DWELL;
                end
            end
            DWELL: begin
                cnt_nx = cnt - DWELL_WIDTH'(1);
                if (cnt == DWELL_WIDTH'(1)) begin
                    state_nx = STEP;
                end
            end
            STEP: begin
                load_freq = 1'b1;
`ifdef DSP_NCO_SWEEP_BIDIR_EN
                if (!dir_q) begin
                    if (up_ok) begin
                        phi_nx = up_sum[PHI_WIDTH-1:0];
                    end else if (dn_ok) begin
                        phi_nx = dn_diff[PHI_WIDTH-1:0];
                        dir_nx = 1'b1;
                    end else begin
                        sweep_end = 1'b1;
                    end
                end else if (dn_ok) begin
                    phi_nx = dn_diff[PHI_WIDTH-1:0];
                end else if (cont_lat) begin
                    // bottom turnaround: head back up from where the down-sweep stopped
                    dir_nx = 1'b0;
                    phi_nx = up_ok ? up_sum[PHI_WIDTH-1:0] : fs_lat;
                end else begin
                    sweep_end = 1'b1;
                end
`else
                if (up_ok) begin
                    phi_nx = up_sum[PHI_WIDTH-1:0];
                end else begin
                    sweep_end = 1'b1;
                end
`endif
                if (sweep_end) begin
                    if (cont_lat) begin
                        phi_nx = fs_lat;
                        dir_nx = 1'b0;
                    end else begin
                        load_freq = 1'b0;
                        state_nx  = DONE;
                    end
                end
                if (load_freq) begin
                    stb_nx   = 1'b1;
                    cnt_nx   = hold_lat;
                    state_nx = (hold_lat == '0) ? STEP : DWELL;
                end
            end
            DONE: begin
                state_nx = IDLE;
                dir_nx   = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
            phi_nx   = phi;
            cnt_nx   = cnt;
            stb_nx   = 1'b0;
            dir_nx   = 1'b0;
        end
    end

    assign busy        = (state == DWELL) || (state == STEP);
    assign nco_en      = busy;
    assign done        = (state == DONE);
    assign step_stb    = stb_q;
    assign nco_phi_inc = phi;
`ifdef DSP_NCO_SWEEP_BIDIR_EN
    assign dir = dir_q;
`else
    assign dir = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_nco_sweep_ctrl.sv
// Self-checking bench for dsp_nco_sweep_ctrl: directed sweep table, hand-written corner
// sequences and random start/abort traffic, all compared cycle by cycle against a
// frequency-list reference model.
module tb_dsp_nco_sweep_ctrl;

    localparam int PW = 14;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cont = 1'b0;
    logic [PW-1:0] f_start = '0;
    logic [PW-1:0] f_stop = '0;
    logic [PW-1:0] f_step = '0;
    logic [DW-1:0] dwell = '0;
    logic          nco_en;
    logic [PW-1:0] nco_phi_inc;
    logic          busy;
    logic          step_stb;
    logic          done;
    logic          dir;

    int vectors = 0;
    int errors  = 0;

    // reference model state
    bit m_act, m_done, m_stb, m_dir, c_cont;
    int m_phi, m_left, c_fs, c_stop, c_step, c_dw;

    dsp_nco_sweep_ctrl #(.PHI_WIDTH(PW), .DWELL_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
        .nco_en(nco_en), .nco_phi_inc(nco_phi_inc), .busy(busy),
        .step_stb(step_stb), .done(done), .dir(dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_act = 0; m_done = 0; m_stb = 0; m_dir = 0; m_phi = 0; m_left = 0;
        c_fs = 0; c_stop = 0; c_step = 0; c_dw = 0; c_cont = 0;
    endfunction

    // choose the frequency that follows the current one, or finish the sweep
    function automatic void model_next();
        int up = m_phi + c_step;
        int dn = m_phi - c_step;
        bit up_ok = (c_step != 0) && (up <= c_stop);
        bit dn_ok = (c_step != 0) && (dn >= c_fs);
        bit fin = 0;
`ifdef DSP_NCO_SWEEP_BIDIR_EN
        if (!m_dir) begin
            if (up_ok) m_phi = up;
            else if (dn_ok) begin m_phi = dn; m_dir = 1; end
            else fin = 1;
        end else begin
            if (dn_ok) m_phi = dn;
            else if (c_cont) begin m_dir = 0; m_phi = up_ok ? up : c_fs; end
            else fin = 1;
        end
`else
        if (up_ok) m_phi = up;
        else fin = 1;
`endif
        if (fin) begin
            if (c_cont) begin
                m_phi = c_fs;
                m_dir = 0;
            end else begin
                m_act  = 0;
                m_done = 1;
                return;
            end
        end
        m_stb  = 1;
        m_left = (c_dw == 0) ? 1 : c_dw;
    endfunction

    function automatic void model_edge();
        m_stb = 0;
        if (abort) begin
            m_act = 0; m_done = 0; m_dir = 0;
        end else if (m_done) begin
            m_done = 0; m_dir = 0;
        end else if (!m_act) begin
            if (start) begin
                c_fs = int'(f_start); c_stop = int'(f_stop); c_step = int'(f_step);
                c_dw = int'(dwell); c_cont = cont;
                m_act = 1; m_phi = c_fs; m_dir = 0; m_stb = 1;
                m_left = (c_dw == 0) ? 1 : c_dw;
            end
        end else begin
            m_left--;
            if (m_left == 0) model_next();
        end
    endfunction

    // one clock: update the model at the edge, compare all outputs 1 time unit later
    task automatic tick();
        logic [18:0] exp_v;
        @(posedge clk);
        model_edge();
        #1;
        exp_v = {m_act, m_act, m_stb, m_done, m_dir, PW'(m_phi)};
        check("cycle {en,busy,stb,done,dir,phi}",
              {13'd0, nco_en, busy, step_stb, done, dir, nco_phi_inc}, {13'd0, exp_v});
    endtask

    typedef struct {
        logic [PW-1:0] fs, fstop, fstep;
        logic [DW-1:0] dw;
        int            exp_cycles;
        int            exp_stb;
        logic [PW-1:0] exp_final;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cycles, stbs;
        bit seen_done;
        logic [PW-1:0] last_phi;

        tbl[0] = '{14'd100,   14'd130,   14'd10, 16'd4, 16, 4, 14'd130};
        tbl[1] = '{14'd5,     14'd7,     14'd1,  16'd0, 3,  3, 14'd7};
        tbl[2] = '{14'd16380, 14'd16383, 14'd10, 16'd2, 2,  1, 14'd16380};
        tbl[3] = '{14'd50,    14'd20,    14'd5,  16'd3, 3,  1, 14'd50};
        tbl[4] = '{14'd40,    14'd90,    14'd0,  16'd2, 2,  1, 14'd40};
        tbl[5] = '{14'd0,     14'd3,     14'd1,  16'd1, 4,  4, 14'd3};
`ifdef DSP_NCO_SWEEP_BIDIR_EN
        tbl[0] = '{14'd100,   14'd130,   14'd10, 16'd4, 28, 7, 14'd100};
        tbl[1] = '{14'd5,     14'd7,     14'd1,  16'd0, 5,  5, 14'd5};
        tbl[5] = '{14'd0,     14'd3,     14'd1,  16'd1, 7,  7, 14'd0};
`endif

        model_reset();
        #13;
        check("reset outputs", {26'd0, nco_en, busy, step_stb, done, dir},
              32'd0);
        check("reset phi", {18'd0, nco_phi_inc}, 32'd0);
        rst_n = 1'b1;
        tick();

        // directed single-shot sweeps
        for (int v = 0; v < 6; v++) begin
            f_start = tbl[v].fs; f_stop = tbl[v].fstop; f_step = tbl[v].fstep;
            dwell = tbl[v].dw; cont = 1'b0; start = 1'b1;
            tick();
            start = 1'b0;
            cycles = 0; stbs = 0; seen_done = 0; last_phi = '0;
            for (int i = 0; i < 2000 && !seen_done; i++) begin
                if (busy) cycles++;
                if (step_stb) stbs++;
                last_phi = nco_phi_inc;
                if (done) seen_done = 1;
                else tick();
            end
            check("table done seen", {31'd0, seen_done}, 32'd1);
            check("table active cycles", cycles, tbl[v].exp_cycles);
            check("table step_stb count", stbs, tbl[v].exp_stb);
            check("table final phi", {18'd0, last_phi}, {18'd0, tbl[v].exp_final});
            tick();
            tick();
        end

        // continuous sweep: wrap at cycle 16, abort at cycle 30
        f_start = 14'd100; f_stop = 14'd130; f_step = 14'd10; dwell = 16'd4;
        cont = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 16; i++) tick();
`ifdef DSP_NCO_SWEEP_BIDIR_EN
        check("cont cycle16 phi", {18'd0, nco_phi_inc}, 32'd120);
        check("cont cycle16 dir", {31'd0, dir}, 32'd1);
`else
        check("cont cycle16 phi", {18'd0, nco_phi_inc}, 32'd100);
`endif
        check("cont cycle16 stb", {31'd0, step_stb}, 32'd1);
        for (int i = 17; i < 30; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort nco_en/busy/done", {29'd0, nco_en, busy, done}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) seen_done = 1;
        end
        check("abort no done", {31'd0, seen_done}, 32'd0);

        // start while busy is ignored; then async reset mid-sweep
        cont = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 3; i++) tick();
        f_start = 14'd999; start = 1'b1;
        tick();
        start = 1'b0;
        check("start during busy phi", {18'd0, nco_phi_inc}, 32'd100);
        for (int i = 4; i < 6; i++) tick();
        #3 rst_n = 1'b0;
        #1;
        check("async reset outputs", {26'd0, nco_en, busy, step_stb, done, dir}, 32'd0);
        check("async reset phi", {18'd0, nco_phi_inc}, 32'd0);
        model_reset();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // start together with abort resolves to abort
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start+abort stays idle", {30'd0, nco_en, busy}, 32'd0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                f_start = 14'(16383 - $urandom_range(0, 60));
                f_stop  = 14'(16383 - $urandom_range(0, 60));
            end else begin
                f_start = 14'($urandom_range(0, 300));
                f_stop  = 14'($urandom_range(0, 400));
            end
            f_step = 14'($urandom_range(0, 40));
            dwell  = 16'($urandom_range(0, 3));
            cont   = ($urandom_range(0, 3) == 0);
            start  = busy ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
            abort  = ($urandom_range(0, 99) == 0);
            tick();
        end
        start = 1'b0; abort = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
